// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage RISC-V pipeline control: forwarding selects,
// hazard FSM states and register-address width.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding select for one E-stage source operand.
// The M stage wins over W because it holds the younger result.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic                  regWriteM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteW,
    output fwd_sel_e              fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
            fwdSel = FWD_M;
        end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
            fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush and
// data-memory wait FSM with watchdog. Counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemErr,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam int                WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state;
    logic [WAIT_W-1:0] waitCnt;
    logic              memErrQ;
    logic              memStall;
    logic              lwStall;
    logic              branch;
    fwd_sel_e          fwdA;
    fwd_sel_e          fwdB;

    // Every control output is forced quiet while rst is held.
    always_comb begin
        memStall = ((state == RUN) & MemReqM & ~MemReadyM)
                 | ((state == MEM_WAIT) & ~MemReadyM);
        memStall = memStall & ~rst;
        lwStall  = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D))
                 & ~PCSrcE & ~rst;
        branch   = PCSrcE & ~rst;
    end

    assign StallF = lwStall | memStall;
    assign StallD = lwStall | memStall;
    assign StallE = memStall;
    assign StallM = memStall;
    assign FlushW = memStall;
    // E is frozen during a memory stall, so a held branch flushes on release.
    assign FlushD = branch & ~memStall;
    assign FlushE = (lwStall | branch) & ~memStall;

    forward_unit fwdUnitA (
        .rsE       (Rs1E),
        .rdM       (RdM),
        .regWriteM (RegWriteM),
        .rdW       (RdW),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdA)
    );

    forward_unit fwdUnitB (
        .rsE       (Rs2E),
        .rdM       (RdM),
        .regWriteM (RegWriteM),
        .rdW       (RdW),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdB)
    );

    assign ForwardAE = rst ? FWD_RF : fwdA;
    assign ForwardBE = rst ? FWD_RF : fwdB;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
            memErrQ <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    waitCnt <= '0;
                    if (MemReqM && !MemReadyM) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else begin
                        // Saturate so a very long wait cannot wrap the watchdog.
                        if (waitCnt != '1) begin
                            waitCnt <= waitCnt + WAIT_W'(1);
                        end
                        if (waitCnt >= LAST_WAIT) begin
                            memErrQ <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    assign MemErr = memErrQ & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (StallF) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (FlushD || FlushE) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign StallCycles = rst ? '0 : stallCnt;
    assign FlushCount  = rst ? '0 : flushCnt;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               step;
        logic [3:0]       stall;   // {F, D, E, M}
        logic [2:0]       flush;   // {D, E, W}
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             memErr;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon;
    int   checks = 0;
    int   fails  = 0;
    int   stepNo = 0;
    int   accStall = 0;
    int   accFlush = 0;

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counter expectations accumulate from the hand-written stall/flush values.
    task automatic want(input logic [3:0] st, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic me);
        exp_t e;
        e.step = stepNo; e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb; e.memErr = me;
        if (rst) begin
            accStall = 0; accFlush = 0;
            e.sc = '0; e.fc = '0;
        end else begin
            e.sc = PERF ? CNT_W'(accStall) : '0;
            e.fc = PERF ? CNT_W'(accFlush) : '0;
            accStall += int'(st[3]);
            accFlush += int'(fl[2] | fl[1]);
        end
        sbq.push_back(e);
        stepNo++;
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            mon = sbq.pop_front();
            chk("stall",   mon.step, 32'({StallF, StallD, StallE, StallM}), 32'(mon.stall));
            chk("flush",   mon.step, 32'({FlushD, FlushE, FlushW}), 32'(mon.flush));
            chk("fwdA",    mon.step, 32'(ForwardAE), 32'(mon.fa));
            chk("fwdB",    mon.step, 32'(ForwardBE), 32'(mon.fb));
            chk("memErr",  mon.step, 32'(MemErr), 32'(mon.memErr));
            chk("stallCnt", mon.step, 32'(StallCycles), 32'(mon.sc));
            chk("flushCnt", mon.step, 32'(FlushCount), 32'(mon.fc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        idle();
        // Reset with hazard-looking inputs: everything quiet
        for (int i = 0; i < 2; i++) begin
            tick(); idle(); rst = 1; MemReqM = 1; RegWriteM = 1; RdM = 3; Rs1E = 3;
            want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        end
        tick(); idle(); rst = 0;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Load-use: lw x5 in E, add x6,x5,x1 in D
        tick(); idle(); ResultSrcE0 = 1; RdE = 5; Rs1D = 5; Rs2D = 1;
        want(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        tick(); idle(); RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 1;
        want(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0);
        // Load-use via Rs2D
        tick(); idle(); ResultSrcE0 = 1; RdE = 7; Rs1D = 2; Rs2D = 7;
        want(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        // Load into x0 never stalls
        tick(); idle(); ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Forwarding priority
        tick(); idle(); RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3; Rs2E = 3;
        want(4'b0000, 3'b000, 2'b10, 2'b10, 1'b0);
        tick(); idle(); RdM = 0; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3; Rs2E = 7;
        want(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0);
        tick(); idle(); RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0; Rs2E = 0;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick(); idle(); RdM = 4; RdW = 6; RegWriteM = 0; RegWriteW = 1; Rs1E = 4; Rs2E = 6;
        want(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);

        // Taken branch suppresses the load-use stall
        tick(); idle(); PCSrcE = 1; ResultSrcE0 = 1; RdE = 5; Rs1D = 5;
        want(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        tick(); idle();
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Memory wait of 3 cycles, ready on the 4th
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); MemReqM = 1;
            want(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        tick(); idle(); MemReqM = 1; MemReadyM = 1;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        // Same-cycle ready costs nothing
        tick(); idle(); MemReqM = 1; MemReadyM = 1;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick(); idle();
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Branch during a memory wait is deferred to the release cycle
        tick(); idle(); MemReqM = 1;
        want(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(); idle(); MemReqM = 1; PCSrcE = 1;
            want(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        tick(); idle(); MemReqM = 1; MemReadyM = 1; PCSrcE = 1;
        want(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        tick(); idle();
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Watchdog: MemErr after 4 MEM_WAIT cycles; forwarding still live
        for (int i = 0; i < 8; i++) begin
            tick(); idle(); MemReqM = 1; RegWriteM = 1; RdM = 9; Rs1E = 9;
            want(4'b1111, 3'b001, 2'b10, 2'b00, (i >= 5));
        end
        tick(); idle(); MemReqM = 1; MemReadyM = 1;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        tick(); idle(); MemReqM = 1;
        want(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);

        // Reset taken while in MEM_WAIT
        tick(); idle(); rst = 1; MemReqM = 1;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick(); idle(); rst = 0;
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick(); idle(); ResultSrcE0 = 1; RdE = 8; Rs2D = 8;
        want(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        tick(); idle();
        want(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        tick(); tick();
        chk("drain", stepNo, 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. It resolves RAW forwarding, load-use stalls, taken-branch flushes and multi-cycle data-memory waits, the last through a small FSM with a timeout watchdog. It sits beside the datapath and observes register addresses and control bits from stages D, E, M and W.

## Interface
- MEM_TIMEOUT, 255: number of MEM_WAIT cycles before MemErr is raised; 1..65535.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in E
- ResultSrcE0  in  1  the instruction in E is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- RdM, RdW  in  5  destinations in M and W
- RegWriteM, RegWriteW  in  1  register-write enables in M and W
- MemReqM  in  1  the instruction in M accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E and E/M registers (drive EN = ~Stall)
- FlushD, FlushE, FlushW  out  1  synchronous clear of the F/D, D/E and M/W registers
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result
- MemErr  out  1  sticky memory-timeout flag
- StallCycles, FlushCount  out  CNT_W  performance counters

## Operation
- FSM states are RUN and MEM_WAIT. Reset goes to RUN and clears the wait counter and MemErr.
- RUN to MEM_WAIT: MemReqM=1 and MemReadyM=0. MEM_WAIT to RUN: MemReadyM=1.
- memStall = (RUN & MemReqM & ~MemReadyM) | (MEM_WAIT & ~MemReadyM). It is combinational, so a same-cycle ready produces zero stall cycles.
- lwStall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE. It is suppressed on a taken branch because the D instruction is squashed anyway.
- StallF = StallD = lwStall | memStall. StallE = StallM = memStall. FlushW = memStall, which inserts a bubble into W.
- FlushD = PCSrcE & ~memStall. FlushE = (lwStall | PCSrcE) & ~memStall.
- A branch seen during a memory stall is therefore deferred. E is frozen, so PCSrcE persists and the flush fires on the release cycle.
- ForwardAE rules, in priority order:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
- ForwardBE follows the same rules using Rs2E.
- Forwarding stays active during stalls.
- Watchdog: the wait counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT. When the count reaches MEM_TIMEOUT, MemErr sets and stays set until rst. The FSM keeps waiting.

## Timing
- All Stall, Flush and Forward outputs are combinational from the inputs and the registered state.
- State, the wait counter, MemErr and the counters update on posedge clk.
- While rst=1, every Stall and Flush output is 0, ForwardAE/BE are 00, and MemErr, StallCycles and FlushCount are 0. The pipeline registers clear themselves on rst.
- Reset in MEM_WAIT returns to RUN on the next edge with no pending state.
- Load-use costs exactly 1 bubble. A taken branch costs 2 bubbles. A memory wait of N cycles until MemReadyM costs N stall cycles.
- The counters wrap modulo 2^CNT_W.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCycles increments on every cycle with StallF=1.
  - FlushCount increments on every cycle with FlushD|FlushE.
- HAZARD_PERF_CNT_EN undefined: the counter logic is removed and both ports are tied to 0, keeping the port list identical.

## Structure
- Shared package pipeline_pkg holds:
  - the fwd_sel_e enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - the hz_state_e enum {RUN, MEM_WAIT};
  - the REG_ADDR_W=5 constant.
- One sub-module, forward_unit, is instantiated twice (operands A and B). It is the pure combinational comparator for one operand.

## Test plan
- Load-use: lw x5 in E (RdE=5, ResultSrcE0=1) with add x6,x5,x1 in D (Rs1D=5) gives StallF=StallD=FlushE=1 for 1 cycle, then ForwardAE=10.
- Forwarding priority: RdM=RdW=3 with both RegWrite=1 and Rs1E=3 gives ForwardAE=10. With RdM=0 and RdW=3, ForwardAE=01. With RdW=0 and RegWriteW=1, ForwardAE=00.
- Branch: PCSrcE=1 together with a load-use match gives FlushD=FlushE=1, StallF=0, and FlushCount +1.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles gives all Stall outputs and FlushW =1 for 3 cycles, StallCycles +3, and RUN on the ready cycle. With MemReadyM=1 immediately, there are no stall cycles.
- Deferred flush: PCSrcE=1 during MEM_WAIT keeps FlushD/E=0 until MemReadyM, then FlushD=FlushE=1 for one cycle.
- Timeout and reset: with MEM_TIMEOUT=4 and ready held low, MemErr rises after 4 MEM_WAIT cycles and stays high. Asserting rst clears MemErr and the counters and returns the FSM to RUN.
